// File: rtl/proc_io_pkg.sv
// ---------------------------------------------------------------------------
// proc_io_pkg
//   Shared definitions for the processor result output stage.
//   - tx_state_e     : UART transmitter FSM states
//   - BYTES_PER_WORD : bytes serialised per 32-bit result word
//   - UART_DATA_BITS : data bits per UART character
//   Build option: RESULT_TX_PARITY_EN adds the PARITY state (8E1 frames).
// ---------------------------------------------------------------------------
package proc_io_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef RESULT_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered occupancy count.
//   Parameters: WIDTH (data width), DEPTH (entries, power of two, >= 2).
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, wdata     write request / data (ignored while full)
//     pop             read request (ignored while empty)
//     rdata           head-of-queue word (valid while !empty)
//     full, empty     decoded from the registered count
//     count           number of stored words
//   A push while full is refused even if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says so.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// ---------------------------------------------------------------------------
// result_uart_tx
//   Buffers 32-bit processor results and sends each as four UART bytes,
//   most-significant byte first, 8N1 (8E1 with RESULT_TX_PARITY_EN).
//   Parameters: CLKS_PER_BIT (>= 2), FIFO_DEPTH (power of two, >= 2).
//   Ports:
//     clk        system clock
//     reset      asynchronous active-low reset
//     ans_in     result word
//     ans_valid  ans_in holds a word; accepted when ans_valid && ans_ready
//     ans_ready  FIFO not full
//     tx         serial line, idles high, driven from a flop
//     busy       FIFO non-empty or frame in progress
//     drop_cnt   cycles with ans_valid && !ans_ready, saturating at 255
//   Handshake: a word transfers on the rising edge where ans_valid and
//   ans_ready are both high; ans_ready depends only on registered state.
//   Build option: RESULT_TX_PARITY_EN inserts an even-parity bit.
// ---------------------------------------------------------------------------
module result_uart_tx
    import proc_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ans_in,
    input  logic        ans_valid,
    output logic        ans_ready,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        state_q, state_d;
    logic [TMR_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [7:0]       drop_q, drop_d;

    logic             fifo_pop;
    logic [31:0]      fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic             bit_end;
    logic [7:0]       cur_byte;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (ans_valid),
        .wdata (ans_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ans_ready = !fifo_full;
    assign tx        = tx_q;
    assign busy      = (fifo_count != '0) || (state_q != IDLE);
    assign drop_cnt  = drop_q;
    assign bit_end   = (bit_cnt_q == TMR_W'(CLKS_PER_BIT - 1));

    // The byte on the wire is always the top byte; the register shifts up
    // by one byte when moving to the next byte of the word.
    assign cur_byte  = shift_q[31:24];

    // tx_d is the level of the bit being entered, so tx_q changes on the
    // same edge as the state that owns that bit.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_end ? '0 : bit_cnt_q + TMR_W'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                tx_d      = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_rdata;
                    byte_idx_d = 2'(BYTES_PER_WORD - 1);
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = cur_byte[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef RESULT_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^cur_byte;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end

`ifdef RESULT_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q != 2'd0) begin
                        byte_idx_d = byte_idx_q - 2'd1;
                        shift_d    = {shift_q[23:0], 8'h00};
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else if (!fifo_empty) begin
                        // Next word follows with no idle gap.
                        fifo_pop   = 1'b1;
                        shift_d    = fifo_rdata;
                        byte_idx_d = 2'(BYTES_PER_WORD - 1);
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
            end
        endcase
    end

    // Counts refused cycles, not refused words.
    always_comb begin
        drop_d = drop_q;
        if (ans_valid && !ans_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_result_uart_tx.sv
`timescale 1ns/1ps
module tb_result_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef RESULT_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BYTE_CYC = FRAME_BITS * CPB;
  localparam int WORD_CYC = 4 * BYTE_CYC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ans_in = '0;
  logic        ans_valid = 1'b0;
  logic        ans_ready;
  logic        tx;
  logic        busy;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];

  result_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ans_in    (ans_in),
    .ans_valid (ans_valid),
    .ans_ready (ans_ready),
    .tx        (tx),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- UART receiver model ----------------
  // Samples tx on negedges; cnt 0 is the first low sample of a start bit,
  // each bit is sampled one sample after its first.
  bit         mon_active = 1'b0;
  bit         mon_prev = 1'b1;
  int         mon_cnt = 0;
  int         mon_bit;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
      mon_prev   = 1'b1;
    end else begin
      if (!mon_active) begin
        if (mon_prev && !tx) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          start_q.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == 1) begin
          mon_bit = mon_cnt / CPB;
          if (mon_bit == 0) begin
            n_vec++;
            if (tx !== 1'b0) begin
              n_err++;
              $display("FAIL start_bit: got %b expected 0", tx);
            end
          end else if (mon_bit <= 8) begin
            mon_byte[mon_bit-1] = tx;
          end
`ifdef RESULT_TX_PARITY_EN
          if (mon_bit == 9) begin
            n_vec++;
            if (tx !== ^mon_byte) begin
              n_err++;
              $display("FAIL parity_bit: byte %02h got %b expected %b", mon_byte, tx, ^mon_byte);
            end
          end
`endif
          if (mon_bit == FRAME_BITS - 1) begin
            n_vec++;
            if (tx !== 1'b1) begin
              n_err++;
              $display("FAIL stop_bit: got %b expected 1", tx);
            end
            rx_q.push_back(mon_byte);
            mon_active = 1'b0;
          end
        end
      end
      mon_prev = tx;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    ans_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    rx_q.delete();
    start_q.delete();
  endtask

  task automatic push_word_bytes(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic wait_idle(input int limit, output int waited);
    waited = 0;
    while (busy === 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({tx, ans_ready, busy} !== 3'b110 || drop_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL reset_hold: tx/ready/busy=%b%b%b drop=%0d expected 110 drop=0",
                 tx, ans_ready, busy, drop_cnt);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if ({tx, ans_ready, busy} !== 3'b110 || drop_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL reset_idle: tx/ready/busy=%b%b%b drop=%0d expected 110 drop=0",
                 tx, ans_ready, busy, drop_cnt);
      end
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic [7:0]  b0;
    logic        exp_bit;
    int          t_acc;
    int          waited;
    w  = 32'hA5C30F01;
    b0 = w[31:24];
    apply_reset();
    ans_in = w;
    ans_valid = 1'b1;
    n_vec++;
    if (ans_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: got %b expected 1", ans_ready);
    end
    push_word_bytes(w);
    @(negedge clk);                 // edge N accepted the word
    ans_valid = 1'b0;
    t_acc = cyc;
    n_vec++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_after_accept: tx=%b busy=%b expected tx=1 busy=1", tx, busy);
    end
    @(negedge clk);                 // edge N+1: start bit
    for (int s = 0; s < 10 * CPB; s++) begin
      int b;
      b = s / CPB;
      if (b == 0) exp_bit = 1'b0;
      else if (b <= 8) exp_bit = b0[b-1];
`ifdef RESULT_TX_PARITY_EN
      else exp_bit = ^b0;
`else
      else exp_bit = 1'b1;
`endif
      n_vec++;
      if (tx !== exp_bit) begin
        n_err++;
        $display("FAIL single_bit: sample %0d got %b expected %b", s, tx, exp_bit);
      end
      @(negedge clk);
    end
    wait_idle(WORD_CYC + 100, waited);
    n_vec++;
    if (busy !== 1'b0 || (cyc - t_acc) != 1 + WORD_CYC) begin
      n_err++;
      $display("FAIL single_busy_fall: busy=%b after %0d edges expected 0 after %0d",
               busy, cyc - t_acc, 1 + WORD_CYC);
    end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL single_byte_count: got %0d expected %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      logic [7:0] e;
      logic [7:0] r;
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      n_vec++;
      if (r !== e) begin
        n_err++;
        $display("FAIL single_byte: got %02h expected %02h", r, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words[6];
    int          acc_rel[6];
    int          k;
    int          rel;
    int          waited;
    bit          exp_rdy;
    apply_reset();
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    k = 0;
    rel = 0;
    ans_in = words[0];
    ans_valid = 1'b1;
    while (k < 6 && rel < 2 * WORD_CYC) begin
      exp_rdy = (rel <= DEPTH) || (rel >= WORD_CYC + 2);
      n_vec++;
      if (ans_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL bp_ready: before edge %0d got %b expected %b", rel, ans_ready, exp_rdy);
      end
      if (ans_ready === 1'b1) begin
        acc_rel[k] = rel;
        push_word_bytes(words[k]);
        k++;
      end
      @(negedge clk);
      if (k < 6) ans_in = words[k];
      else ans_valid = 1'b0;
      rel++;
    end
    ans_valid = 1'b0;
    n_vec++;
    if (k != 6 || acc_rel[5] != WORD_CYC + 2) begin
      n_err++;
      $display("FAIL bp_sixth_accept: accepted %0d words, last at edge %0d expected 6 at %0d",
               k, acc_rel[5], WORD_CYC + 2);
    end
    n_vec++;
    if (drop_cnt !== 8'(WORD_CYC + 2 - (DEPTH + 1))) begin
      n_err++;
      $display("FAIL bp_drop_cnt: got %0d expected %0d", drop_cnt, WORD_CYC + 2 - (DEPTH + 1));
    end
    wait_idle(7 * WORD_CYC, waited);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: busy=%b after %0d cycles expected 0", busy, waited);
    end
    n_vec++;
    if (start_q.size() != 24) begin
      n_err++;
      $display("FAIL bp_frames: got %0d start bits expected 24", start_q.size());
    end
    for (int i = 1; i < start_q.size(); i++) begin
      n_vec++;
      if (start_q[i] - start_q[i-1] != BYTE_CYC) begin
        n_err++;
        $display("FAIL bp_gap: byte %0d spacing got %0d expected %0d",
                 i, start_q[i] - start_q[i-1], BYTE_CYC);
      end
    end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bp_byte_count: got %0d expected %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      logic [7:0] e;
      logic [7:0] r;
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      n_vec++;
      if (r !== e) begin
        n_err++;
        $display("FAIL bp_byte: got %02h expected %02h", r, e);
      end
    end
  endtask

  task automatic test_drop_counter();
    int refused;
    int exp_drop;
    apply_reset();
    refused = 0;
    ans_in = $urandom;
    ans_valid = 1'b1;
    for (int i = 0; i < 2 * WORD_CYC + 100; i++) begin
      exp_drop = (refused > 255) ? 255 : refused;
      n_vec++;
      if (drop_cnt !== 8'(exp_drop)) begin
        n_err++;
        $display("FAIL drop_track: cycle %0d got %0d expected %0d", i, drop_cnt, exp_drop);
      end
      if (ans_ready === 1'b0) refused++;
      @(negedge clk);
      ans_in = $urandom;
    end
    ans_valid = 1'b0;
    n_vec++;
    if (refused < 300 || drop_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL drop_saturate: got %0d after %0d refused cycles expected 255", drop_cnt, refused);
    end
    apply_reset();
    n_vec++;
    if (drop_cnt !== 8'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_reset: drop=%0d busy=%b expected 0 0", drop_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t_acc;
    int guard;
    apply_reset();
    ans_in = 32'h12345678;
    ans_valid = 1'b1;
    @(negedge clk);
    t_acc = cyc;
    ans_in = 32'hDEADBEEF;
    @(negedge clk);
    ans_valid = 1'b0;
    guard = 0;
    while (cyc < t_acc + 1 + BYTE_CYC + CPB + 3 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || ans_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_async: tx=%b busy=%b ready=%b expected 1 0 1", tx, busy, ans_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < WORD_CYC + 40; i++) begin
      @(negedge clk);
      n_vec++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_quiet: cycle %0d tx=%b busy=%b expected 1 0", i, tx, busy);
      end
    end
    n_vec++;
    if (rx_q.size() != 1) begin
      n_err++;
      $display("FAIL midreset_bytes: got %0d bytes expected 1", rx_q.size());
    end else begin
      n_vec++;
      if (rx_q[0] !== 8'h12) begin
        n_err++;
        $display("FAIL midreset_first: got %02h expected 12", rx_q[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int          t;
    int          waited;
    apply_reset();
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 200)) @(negedge clk);
      w = $urandom;
      ans_in = w;
      ans_valid = 1'b1;
      t = 0;
      while (ans_ready !== 1'b1 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      n_vec++;
      if (t >= 1000) begin
        n_err++;
        $display("FAIL rand_ready_timeout: word %0d ready=%b expected 1", n, ans_ready);
      end else begin
        push_word_bytes(w);
      end
      @(negedge clk);
      ans_valid = 1'b0;
    end
    wait_idle(6 * WORD_CYC, waited);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rand_drain: busy=%b expected 0", busy);
    end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rand_byte_count: got %0d expected %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      logic [7:0] e;
      logic [7:0] r;
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      n_vec++;
      if (r !== e) begin
        n_err++;
        $display("FAIL rand_byte: got %02h expected %02h", r, e);
      end
    end
  endtask

`ifdef RESULT_TX_PARITY_EN
  task automatic test_parity();
    int t_acc;
    int waited;
    apply_reset();
    ans_in = 32'h07000000;
    ans_valid = 1'b1;
    @(negedge clk);
    ans_valid = 1'b0;
    t_acc = cyc;
    @(negedge clk);
    repeat (9 * CPB + 1) @(negedge clk);
    n_vec++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL parity_07: got %b expected 1", tx);
    end
    wait_idle(WORD_CYC + 100, waited);
    n_vec++;
    if ((cyc - t_acc) != 1 + 44 * CPB) begin
      n_err++;
      $display("FAIL parity_frame_len: got %0d expected %0d", cyc - t_acc, 1 + 44 * CPB);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_drop_counter();
    test_reset_mid_frame();
    test_random();
`ifdef RESULT_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Downstream output stage of the processor: accepts 32-bit results from the processor's `ans` output with a valid/ready handshake, buffers them in a small FIFO, and serialises each word as four 8N1 UART bytes, most-significant byte first, on a single `tx` line. It sits between the processor top and the board pin, so register-file results can be observed without a simulator.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; must be at least 2.
- `FIFO_DEPTH`, default 4: number of words buffered; must be a power of two and at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ans_in`  in  32  result word from the processor.
- `ans_valid`  in  1  `ans_in` holds a word to send.
- `ans_ready`  out  1  the block can accept a word this cycle.
- `tx`  out  1  UART serial line; idles high.
- `busy`  out  1  the FIFO is non-empty or a frame is in progress.
- `drop_cnt`  out  8  count of cycles with `ans_valid=1` and `ans_ready=0`; saturates at 255.

## Operation
- Handshake:
  - A word is accepted on a rising edge where `ans_valid && ans_ready`.
  - `ans_ready = !fifo_full`, decoded from the registered count.
  - A push in the same cycle as a pop is still refused when the FIFO is full.
- FIFO behaviour:
  - Push and pop may occur in the same cycle; the count is then unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with FIFO non-empty: pop one word into the 32-bit shift register, set the byte index to 3, and go to START.
  - START drives `tx=0` for one bit time, then goes to DATA.
  - DATA drives the 8 bits of the current byte, LSB first. Byte index 3 is `[31:24]`.
  - After DATA, go to PARITY if it is compiled in, otherwise to STOP.
  - STOP drives `tx=1` for one bit time. Then:
    - if the byte index is greater than 0, decrement it and go to START (no idle gap between bytes);
    - else, if the FIFO is non-empty, pop and go to START (back-to-back words);
    - else go to IDLE.
- Bit timer: counts 0 to `CLKS_PER_BIT-1`. The bit ends when the timer is at terminal count; the timer then reloads to 0.
- `drop_cnt` increments once per refused cycle, not once per word.
- Reset values: `tx=1`, `ans_ready=1`, `busy=0`, `drop_cnt=0`, FIFO empty, FSM in IDLE.
- Reset mid-frame: `tx` goes high immediately (asynchronously). The partial byte is abandoned and the buffered words are discarded.

## Timing
- `tx` is driven from a flop; there is no combinational path from any input to `tx`.
- Latency, empty FIFO and IDLE:
  - Word accepted at edge N.
  - Popped at edge N+1.
  - `tx` falls at edge N+1.
- Byte frame length: 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Word frame length: 40×`CLKS_PER_BIT` cycles, or 44× with parity.
- `busy` deasserts on the edge where the final stop bit ends with the FIFO empty.

## Configuration
- `RESULT_TX_PARITY_EN` defined:
  - A PARITY state inserts one even-parity bit, the XOR of the 8 data bits, between DATA and STOP.
  - Frames are 8E1.
- Macro undefined: the PARITY state and its logic are absent, and frames are 8N1.

## Structure
- Package `proc_io_pkg` holds:
  - the FSM state enum;
  - `BYTES_PER_WORD = 4`;
  - `UART_DATA_BITS = 8`.
- One sub-module, `sync_fifo`:
  - parameterised width (32) and depth;
  - outputs `full`, `empty` and `count`;
  - asynchronous active-low reset.
- The FSM, bit timer and shift register live in `result_uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT=4`, `FIFO_DEPTH=4` and no parity.
- Reset:
  - Stimulus: hold `reset=0` for 3 cycles, then release.
  - Required: `tx=1`, `ans_ready=1`, `busy=0` and `drop_cnt=0` throughout, and `tx` stays high with no input.
- Single word:
  - Stimulus: send `0xA5C30F01`.
  - Required: bytes A5, C3, 0F, 01 in that order. The first byte's bits are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `tx` falls 1 edge after acceptance, and `busy` falls 160 cycles later.
- Backpressure:
  - Stimulus: 6 back-to-back valid words.
  - Required: 5 are accepted by edge 4 (4 in the FIFO, 1 in the shifter). `ans_ready` is low from edge 5. The 6th word is accepted the cycle after word 2 is popped at the end of word 1. Words emerge in order with no inter-word gap.
- Drop counter:
  - Stimulus: hold `ans_valid=1` for 300 cycles while the FIFO is full.
  - Required: `drop_cnt` saturates at 255.
- Reset mid-frame:
  - Stimulus: assert `reset` during DATA of byte 2.
  - Required: `tx=1` immediately, and after release no residual bytes are sent.
- Parity build (`RESULT_TX_PARITY_EN` defined):
  - Stimulus: send `0x07000000`.
  - Required: the first byte 07 carries parity bit 1, and the frame is 44 bits long.
